// File: rtl/dmem_arb_pkg.sv
// Shared defaults, FSM state type and grant-vector helper for the data-memory arbiter.
package dmem_arb_pkg;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/dmem_arb_rr2.sv
// Two-requester winner select: round-robin on a tie, or fixed priority to
// requester 0 when DMEM_ARB_FIXED_PRIO_EN is defined.
module dmem_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;
    assign winner      = req[1] & ~req[0];
`else
    // On a tie the requester that did not win last time goes next.
    assign winner = (&req) ? ~last : (req[1] & ~req[0]);
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for a single-port data memory: IDLE -> ACCESS -> RESP per transaction.
// Build option: DMEM_ARB_FIXED_PRIO_EN selects fixed priority (CPU wins ties).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t state;
    logic   win;
    logic   last;
    logic   winner;

    dmem_arb_rr2 u_rr2 (
        .req    (req),
        .last   (last),
        .winner (winner)
    );

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign last = 1'b1;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (state == IDLE && |req)
            last <= winner;
    end
`endif

    // mem_* registers double as the latched request; they are only non-zero in ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            win       <= 1'b0;
            gnt       <= 2'b00;
            done      <= 2'b00;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= ACCESS;
                        win       <= winner;
                        gnt       <= onehot2(winner);
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= we[winner];
                        mem_addr  <= winner ? addr1 : addr0;
                        mem_wdata <= winner ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    gnt       <= 2'b00;
                    done      <= onehot2(win);
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    if (!mem_we)
                        rdata <= mem_rdata;
                end
                RESP: begin
                    state <= IDLE;
                    done  <= 2'b00;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected grants/reads queued at drive time, checked at gnt/done.
module tb_dmem_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] we = 2'b00;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic [1:0] gnt, done;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic       busy, mem_en, mem_we;
    logic [3:0] mem_addr;

    logic [7:0] mem [16] = '{default: 8'h00};

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] gnt;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;
    exp_t q[$];

    dmem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk)
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic w, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] rd);
        exp_t e;
        e.gnt = g; e.we = w; e.addr = a; e.wdata = d; e.rdata = rd;
        q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [3:0] a0,
                         input logic [7:0] d0, input logic [3:0] a1, input logic [7:0] d1);
        @(posedge clk); #1;
        req = r; we = w; addr0 = a0; wdata0 = d0; addr1 = a1; wdata1 = d1;
    endtask

    // Each requester drops its req once granted; returns when everything is idle.
    task automatic serve();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (|gnt) req = req & ~gnt;
        end while ((req != 2'b00 || busy) && n < 40);
        if (n >= 40) chk("serve_timeout", 1, 0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0; req = 2'b00;
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] all_outs();
        return {5'd0, gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata};
    endfunction

    always @(negedge clk) begin
        if (rst_n && (|gnt || |done)) begin
            chk("gnt_done_excl", 32'((|gnt) && (|done)), 0);
            chk("not_both", 32'(gnt == 2'b11 || done == 2'b11), 0);
            if (|gnt) begin
                if (q.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
                else begin
                    chk("gnt", 32'(gnt), 32'(q[0].gnt));
                    chk("mem_en", 32'(mem_en), 1);
                    chk("mem_we", 32'(mem_we), 32'(q[0].we));
                    chk("mem_addr", 32'(mem_addr), 32'(q[0].addr));
                    chk("mem_wdata", 32'(mem_wdata), 32'(q[0].wdata));
                end
            end
            if (|done) begin
                if (q.size() == 0) chk("done_unexpected", 32'(done), 0);
                else begin
                    chk("done", 32'(done), 32'(q[0].gnt));
                    chk("rdata", 32'(rdata), 32'(q[0].rdata));
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int g, n;
        #2;
        chk("reset_outs", all_outs(), 0);
        @(negedge clk); rst_n = 1'b1;

        // CPU write then read with latency check
        push(2'b01, 1'b1, 4'd3, 8'hA5, 8'h00);
        drive(2'b01, 2'b01, 4'd3, 8'hA5, 4'd0, 8'h00);
        serve();
        push(2'b01, 1'b0, 4'd3, 8'h00, 8'hA5);
        drive(2'b01, 2'b00, 4'd3, 8'h00, 4'd0, 8'h00);
        @(posedge clk); @(negedge clk);
        chk("lat_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        @(negedge clk);
        chk("lat_done", 32'(done), 32'h1);
        chk("lat_rdata", 32'(rdata), 32'hA5);
        serve();
        // lone DMA request wins regardless of pointer
        push(2'b10, 1'b1, 4'd4, 8'h42, 8'hA5);
        drive(2'b10, 2'b10, 4'd0, 8'h00, 4'd4, 8'h42);
        serve();

        // tie after reset: CPU first, then DMA
        reset_pulse();
        push(2'b01, 1'b1, 4'd2, 8'h11, 8'h00);
        push(2'b10, 1'b1, 4'd7, 8'h3C, 8'h00);
        drive(2'b11, 2'b11, 4'd2, 8'h11, 4'd7, 8'h3C);
        serve();
        push(2'b01, 1'b0, 4'd7, 8'h00, 8'h3C);
        drive(2'b01, 2'b00, 4'd7, 8'h00, 4'd0, 8'h00);
        serve();

        // fairness: both held for 8 transactions
        reset_pulse();
        for (int i = 0; i < 8; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            push(2'b01, 1'b1, 4'd1, 8'h10, 8'h00);
`else
            if (i % 2 == 0) push(2'b01, 1'b1, 4'd1, 8'h10, 8'h00);
            else            push(2'b10, 1'b1, 4'd2, 8'h20, 8'h00);
`endif
        end
        drive(2'b11, 2'b11, 4'd1, 8'h10, 4'd2, 8'h20);
        g = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (|gnt) g++;
            if (g == 8) req = 2'b00;
        end while ((g < 8 || busy) && n < 100);
        chk("fair_grants", 32'(g), 8);

        // inputs changed during ACCESS are ignored
        push(2'b01, 1'b1, 4'd5, 8'h5A, 8'h00);
        drive(2'b01, 2'b01, 4'd5, 8'h5A, 4'd0, 8'h00);
        @(posedge clk); @(negedge clk); #1;
        addr0 = 4'd9; wdata0 = 8'hFF; req = 2'b00;
        #1;
        chk("ign_addr", 32'(mem_addr), 32'h5);
        chk("ign_wdata", 32'(mem_wdata), 32'h5A);
        serve();
        push(2'b01, 1'b0, 4'd5, 8'hFF, 8'h5A);
        drive(2'b01, 2'b00, 4'd5, 8'hFF, 4'd0, 8'h00);
        serve();
        push(2'b01, 1'b0, 4'd9, 8'h00, 8'h00);
        drive(2'b01, 2'b00, 4'd9, 8'h00, 4'd0, 8'h00);
        serve();

        // reset during a write ACCESS cycle
        push(2'b01, 1'b1, 4'd11, 8'h77, 8'h00);
        drive(2'b01, 2'b01, 4'd11, 8'h77, 4'd0, 8'h00);
        @(posedge clk); @(negedge clk); #1;
        rst_n = 1'b0; req = 2'b00;
        #1;
        chk("midrst_outs", all_outs(), 0);
        void'(q.pop_front());
        repeat (2) begin
            @(negedge clk);
            chk("midrst_nodone", 32'(done), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'({busy, gnt, done}), 0);
        push(2'b01, 1'b0, 4'd5, 8'h00, 8'h5A);
        push(2'b10, 1'b0, 4'd11, 8'h00, 8'h00);
        drive(2'b11, 2'b00, 4'd5, 8'h00, 4'd11, 8'h00);
        serve();

        // idle
        req = 2'b00;
        repeat (10) begin
            @(negedge clk);
            chk("idle", 32'({busy, mem_en, gnt, done}), 0);
        end

        chk("queue_drained", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
